tramvai_module: RTL and testbench
=================================

TRAMVAI_MODULE -- requirements
Module: tramvai_module

Interface
REQ-001 Parameter SECUNDE_VERDE, default 20: steady tram-green duration in seconds.
REQ-002 Parameter SECUNDE_INTERMITENT, default 4: flashing-green duration in seconds.
REQ-003 Parameter SECUNDE_GALBEN, default 3: yellow duration in seconds.
REQ-004 Parameter DIV_FACTOR_SEC, default 10000000: clk cycles per second; the value SHALL be even and at least 2.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 enable  input  1  phase request from the general FSM, level-held until done is seen.
REQ-008 clear  input  1  phase release from the general FSM: terminates the phase and returns the block to IDLE.
REQ-009 tram_req  input  1  tram presence pulse from the track sensor, one or more cycles long.
REQ-010 done  output  1  phase-complete acknowledge, held high until clear.
REQ-011 rosu, galben, verde  output  1 each  tram signal lamps, registered outputs.
REQ-012 req_pending  output  1  a latched tram request is waiting to be served.

Function
REQ-013 The FSM SHALL have the states IDLE, VERDE, INTERMITENT, GALBEN and DONE.
REQ-014 Lamp encoding:
- IDLE and DONE: rosu=1.
- VERDE: verde=1.
- INTERMITENT: verde follows the blink rule (REQ-018).
- GALBEN: galben=1.
- All lamps not listed for a state SHALL be 0.
REQ-015 Entering VERDE:
- The transition IDLE->VERDE SHALL occur on the first edge where enable=1 and clear=0.
- verde=1 and rosu=0 SHALL appear one cycle after enable is sampled.
REQ-016 Prescaler:
- The prescaler SHALL count 0..DIV_FACTOR_SEC-1 and wrap to 0.
- The wrap SHALL produce a one-cycle tick.
- Prescaler and seconds counter SHALL reset to 0 on every state entry, so each state lasts exactly N*DIV_FACTOR_SEC cycles.
REQ-017 Timed transitions:
- VERDE->INTERMITENT after SECUNDE_VERDE ticks.
- INTERMITENT->GALBEN after SECUNDE_INTERMITENT ticks.
- GALBEN->DONE after SECUNDE_GALBEN ticks.
REQ-018 Blink rule in INTERMITENT: verde=1 while prescaler < DIV_FACTOR_SEC/2, else verde=0 (1 Hz, 50% duty).
REQ-019 DONE behaviour:
- done=1 and rosu=1.
- The block SHALL hold DONE regardless of enable until clear=1.
- On clear it SHALL go to IDLE with done=0 on the next cycle.
REQ-020 Clear priority:
- clear=1 in any state SHALL force IDLE on the next edge, with rosu=1, all counters 0 and done=0.
- clear has priority over enable; no other lamp may be on during that edge.
REQ-021 Request latch:
- tram_req=1 SHALL set req_pending on the next edge.
- req_pending SHALL clear on entry to VERDE.
- If tram_req=1 on the same edge that VERDE is entered, req_pending SHALL stay 0.
- tram_req is ignored for the latch while the block is in VERDE, INTERMITENT or GALBEN.
REQ-022 Counter widths:
- Each counter SHALL be wide enough to hold its maximum parameter value.
- No counter SHALL wrap before its terminal count.
- A parameter value of 0 for any duration SHALL skip that state: the block passes through it in one cycle with no tick.

Reset
REQ-023 Asserting rst SHALL immediately (asynchronously) force IDLE with rosu=1, galben=0, verde=0, done=0, req_pending=0 and all counters 0.
REQ-024 Reset released mid-phase SHALL restart in IDLE and wait for a new enable.

Configuration
REQ-025 Macro TRAMVAI_SKIP_EN, when defined:
- In IDLE, enable=1 with req_pending=0 SHALL go directly to DONE on the next edge.
- rosu stays 1 throughout; no lamp changes.
REQ-026 Without TRAMVAI_SKIP_EN:
- Every enable SHALL run the full VERDE/INTERMITENT/GALBEN sequence.
- req_pending is still latched and cleared per REQ-021.

Verification (DIV_FACTOR_SEC=4, SECUNDE_VERDE=3, SECUNDE_INTERMITENT=2, SECUNDE_GALBEN=2)
REQ-027 Nominal phase: enable sampled at cycle 0 ->
- verde=1 over cycles 1-12.
- Blinking over cycles 13-20, with verde=1 on cycles 13,14,17,18.
- galben=1 over cycles 21-28.
- done=1 and rosu=1 from cycle 29.
- clear -> IDLE, done=0.
REQ-028 Clear mid-phase: clear=1 at cycle 5 of VERDE -> next cycle rosu=1, verde=0, done=0; a new enable restarts with a full 12-cycle green.
REQ-029 Async reset: rst asserted mid-GALBEN between clock edges -> galben=0 and rosu=1 without a clock edge; after release, no lamp change until enable.
REQ-030 Skip mode (macro defined): enable with req_pending=0 -> done=1 one cycle later, rosu held 1. With tram_req pulsed first -> req_pending=1, full 28-cycle sequence, and req_pending=0 from cycle 1.
REQ-031 Simultaneity:
- enable=1 and clear=1 on the same edge in IDLE -> remains IDLE.
- tram_req on the VERDE entry edge -> req_pending stays 0.

Source files
------------

// File: rtl/tramvai_module.sv
// Tram signal phase controller: green, flashing green, yellow, then done until cleared.
// Optional TRAMVAI_SKIP_EN: an enable with no latched tram request jumps straight to DONE.
module tramvai_module #(
    parameter int SECUNDE_VERDE       = 20,
    parameter int SECUNDE_INTERMITENT = 4,
    parameter int SECUNDE_GALBEN      = 3,
    parameter int DIV_FACTOR_SEC      = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    input  logic tram_req,
    output logic done,
    output logic rosu,
    output logic galben,
    output logic verde,
    output logic req_pending
);

    localparam int SEC_MAX_VG = (SECUNDE_VERDE > SECUNDE_GALBEN) ? SECUNDE_VERDE : SECUNDE_GALBEN;
    localparam int SEC_MAX    = (SEC_MAX_VG > SECUNDE_INTERMITENT) ? SEC_MAX_VG : SECUNDE_INTERMITENT;
    localparam int SEC_W      = (SEC_MAX < 2) ? 1 : $clog2(SEC_MAX + 1);
    localparam int PRE_W      = $clog2(DIV_FACTOR_SEC);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV_FACTOR_SEC - 1);
    localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(DIV_FACTOR_SEC / 2);
    localparam logic [SEC_W-1:0] VERDE_LAST =
        SEC_W'((SECUNDE_VERDE > 0) ? SECUNDE_VERDE - 1 : 0);
    localparam logic [SEC_W-1:0] INTER_LAST =
        SEC_W'((SECUNDE_INTERMITENT > 0) ? SECUNDE_INTERMITENT - 1 : 0);
    localparam logic [SEC_W-1:0] GALBEN_LAST =
        SEC_W'((SECUNDE_GALBEN > 0) ? SECUNDE_GALBEN - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VERDE,
        S_INTERMITENT,
        S_GALBEN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] preCnt_q, preCnt_d;
    logic [SEC_W-1:0] secCnt_q, secCnt_d;
    logic             req_q, req_d;
    logic             rosu_q, rosu_d;
    logic             galben_q, galben_d;
    logic             verde_q, verde_d;
    logic             done_q, done_d;

    logic tick;
    logic verdeEnd;
    logic interEnd;
    logic galbenEnd;
    logic timedState;

    always_comb begin
        tick       = (preCnt_q == PRE_LAST);
        verdeEnd   = (SECUNDE_VERDE == 0) || (tick && (secCnt_q == VERDE_LAST));
        interEnd   = (SECUNDE_INTERMITENT == 0) || (tick && (secCnt_q == INTER_LAST));
        galbenEnd  = (SECUNDE_GALBEN == 0) || (tick && (secCnt_q == GALBEN_LAST));
        timedState = (state_q == S_VERDE) || (state_q == S_INTERMITENT) ||
                     (state_q == S_GALBEN);

        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
`ifdef TRAMVAI_SKIP_EN
                    state_d = req_q ? S_VERDE : S_DONE;
`else
                    state_d = S_VERDE;
`endif
                end
            end
            S_VERDE:       if (verdeEnd)  state_d = S_INTERMITENT;
            S_INTERMITENT: if (interEnd)  state_d = S_GALBEN;
            S_GALBEN:      if (galbenEnd) state_d = S_DONE;
            S_DONE:        state_d = S_DONE;
            default:       state_d = S_IDLE;
        endcase
        if (clear) begin
            state_d = S_IDLE;
        end

        // Counters only run while staying in a timed state; any entry restarts them at 0.
        preCnt_d = '0;
        secCnt_d = '0;
        if (timedState && (state_d == state_q)) begin
            if (tick) begin
                secCnt_d = secCnt_q + SEC_W'(1);
            end else begin
                preCnt_d = preCnt_q + PRE_W'(1);
                secCnt_d = secCnt_q;
            end
        end

        req_d = req_q;
        if ((state_q == S_IDLE) && (state_d == S_VERDE)) begin
            req_d = 1'b0;
        end else if (tram_req && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
            req_d = 1'b1;
        end

        rosu_d   = (state_d == S_IDLE) || (state_d == S_DONE);
        galben_d = (state_d == S_GALBEN);
        verde_d  = (state_d == S_VERDE) ||
                   ((state_d == S_INTERMITENT) && (preCnt_d < PRE_HALF));
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            preCnt_q <= '0;
            secCnt_q <= '0;
            req_q    <= 1'b0;
            rosu_q   <= 1'b1;
            galben_q <= 1'b0;
            verde_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            preCnt_q <= preCnt_d;
            secCnt_q <= secCnt_d;
            req_q    <= req_d;
            rosu_q   <= rosu_d;
            galben_q <= galben_d;
            verde_q  <= verde_d;
            done_q   <= done_d;
        end
    end

    assign done        = done_q;
    assign rosu        = rosu_q;
    assign galben      = galben_q;
    assign verde       = verde_q;
    assign req_pending = req_q;

endmodule

// File: tb/tb_tramvai_module.sv
// Bench for tramvai_module: directed phases plus random traffic against an elapsed-time model.
module tb_tramvai_module;

    localparam int D     = 4;
    localparam int V     = 3;
    localparam int I     = 2;
    localparam int G     = 2;
    localparam int TOTAL = (V + I + G) * D;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic clear;
    logic tram_req;
    logic done;
    logic rosu;
    logic galben;
    logic verde;
    logic req_pending;

    int errors = 0;
    int checks = 0;

    // Model: mode 0 idle, 1 running, 2 done; mK is the cycle number since enable was taken.
    int mMode = 0;
    int mK    = 0;
    bit mPend = 1'b0;

    tramvai_module #(
        .SECUNDE_VERDE      (V),
        .SECUNDE_INTERMITENT(I),
        .SECUNDE_GALBEN     (G),
        .DIV_FACTOR_SEC     (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .clear      (clear),
        .tram_req   (tram_req),
        .done       (done),
        .rosu       (rosu),
        .galben     (galben),
        .verde      (verde),
        .req_pending(req_pending)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] expectedOut();
        logic r, g, v, d;
        r = 1'b0; g = 1'b0; v = 1'b0; d = 1'b0;
        if (mMode == 0) begin
            r = 1'b1;
        end else if (mMode == 2) begin
            r = 1'b1;
            d = 1'b1;
        end else if (mK <= V * D) begin
            v = 1'b1;
        end else if (mK <= (V + I) * D) begin
            v = (((mK - V * D - 1) % D) < (D / 2));
        end else begin
            g = 1'b1;
        end
        return {r, g, v, d, mPend};
    endfunction

    task automatic modelReset();
        mMode = 0;
        mK    = 0;
        mPend = 1'b0;
    endtask

    task automatic modelEdge(input bit en, input bit clr, input bit treq);
        if (clr) begin
            if (mMode != 1 && treq) mPend = 1'b1;
            mMode = 0;
            mK    = 0;
        end else if (mMode == 0) begin
            if (en) begin
`ifdef TRAMVAI_SKIP_EN
                if (!mPend) begin
                    mMode = 2;
                    if (treq) mPend = 1'b1;
                end else begin
                    mMode = 1;
                    mK    = 1;
                    mPend = 1'b0;
                end
`else
                mMode = 1;
                mK    = 1;
                mPend = 1'b0;
`endif
            end else if (treq) begin
                mPend = 1'b1;
            end
        end else if (mMode == 1) begin
            mK = mK + 1;
            if (mK > TOTAL) mMode = 2;
        end else begin
            if (treq) mPend = 1'b1;
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [4:0] obs;
        logic [4:0] expv;
        obs  = {rosu, galben, verde, done, req_pending};
        expv = expectedOut();
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b (rosu galben verde done req_pending)",
                   tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input bit en, input bit clr, input bit treq, input string tag);
        enable   = en;
        clear    = clr;
        tram_req = treq;
        @(posedge clk);
        modelEdge(en, clr, treq);
        @(negedge clk);
        checkOutput(tag);
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        clear    = 1'b0;
        tram_req = 1'b0;
        #1;
        modelReset();
        checkOutput("reset_state");
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(0, 0, 0, "idle_quiet");
        applyStimulus(1, 1, 0, "enable_and_clear_in_idle");
        applyStimulus(0, 0, 1, "tram_req_latch");
        applyStimulus(0, 0, 0, "tram_req_held");

        applyStimulus(1, 0, 1, "nominal_c1_entry_with_req");
        for (int c = 2; c <= TOTAL + 4; c++) begin
            applyStimulus(1, 0, 0, $sformatf("nominal_c%0d", c));
        end
        applyStimulus(0, 0, 1, "done_req_latch");
        applyStimulus(0, 1, 0, "done_clear");
        applyStimulus(0, 0, 0, "after_clear_idle");

        applyStimulus(1, 0, 0, "midclear_c1");
        for (int c = 2; c <= 5; c++) begin
            applyStimulus(1, 0, 0, $sformatf("midclear_c%0d", c));
        end
        applyStimulus(1, 1, 0, "midclear_clear");
        for (int c = 1; c <= V * D + 2; c++) begin
            applyStimulus(1, 0, 0, $sformatf("restart_c%0d", c));
        end
        applyStimulus(0, 1, 0, "restart_clear");

        for (int c = 1; c <= 23; c++) begin
            applyStimulus(1, 0, 0, $sformatf("prerst_c%0d", c));
        end
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("async_rst_no_edge");
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_held");
        rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(0, 0, 0, $sformatf("post_rst_idle_%0d", c));
        end

        for (int c = 0; c < 2000; c++) begin
            bit en, clr, treq;
            en   = ($urandom_range(0, 3) != 0);
            clr  = (mMode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
            treq = ($urandom_range(0, 7) == 0);
            applyStimulus(en, clr, treq, $sformatf("random_%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
